// File: rtl/mouse_cursor.sv
// mouse_cursor: integrates signed PS/2 packet deltas into an absolute,
// screen-clamped cursor position, tracks button press edges as sticky
// flags and exposes state through a registered CPU read port.
// Pipeline: stage 1 = sign-extend/scale/add, stage 2 = clamp/commit.
module mouse_cursor #(
    parameter int H_MAX  = 639,
    parameter int V_MAX  = 479,
    parameter int H_INIT = 320,
    parameter int V_INIT = 240,
    parameter int SHIFT  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_done_tick,
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    input  logic [2:0]  btn,
    input  logic        home,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    output logic [15:0] rd_data,
    output logic [9:0]  cur_x,
    output logic [9:0]  cur_y,
    output logic [2:0]  btn_level,
    output logic        irq
);

    localparam logic signed [11:0] HMAX12 = 12'(H_MAX);
    localparam logic signed [11:0] VMAX12 = 12'(V_MAX);
    localparam logic [9:0]         HINIT10 = 10'(H_INIT);
    localparam logic [9:0]         VINIT10 = 10'(V_INIT);

    logic               v1;
    logic signed [11:0] sx, sy;
    logic signed [11:0] dx, dy;
    logic [9:0]         clx, cly;
    logic [9:0]         base_x, base_y;
    logic               commit;
    logic               set_moved;
    logic [2:0]         set_press;
    logic               clr;
    logic               moved;
    logic [2:0]         press;
    logic [15:0]        pkt_cnt;

    // 12 bits hold cur (<=1023) plus a delta scaled by up to 4 without overflow
    assign dx = 12'($signed({{3{x[8]}}, x}) <<< SHIFT);
    assign dy = 12'($signed({{3{y[8]}}, y}) <<< SHIFT);

    // Clamp the stage-1 sums to the visible screen
    always_comb begin
        clx = sx[9:0];
        cly = sy[9:0];
        if (sx < 0)            clx = '0;
        else if (sx > HMAX12)  clx = HMAX12[9:0];
        if (sy < 0)            cly = '0;
        else if (sy > VMAX12)  cly = VMAX12[9:0];
    end

    // Stage-1 base: home wins, else forward the pending commit, else current
    always_comb begin
        commit    = v1 & ~home;
        base_x    = cur_x;
        base_y    = cur_y;
        if (home) begin
            base_x = HINIT10;
            base_y = VINIT10;
        end else if (v1) begin
            base_x = clx;
            base_y = cly;
        end
        set_moved = commit & ((clx != cur_x) | (cly != cur_y));
        set_press = m_done_tick ? (btn & ~btn_level) : 3'b000;
        clr       = rd_en & (addr == 2'd2);
    end

    // Stage 1 capture and stage 2 commit of the cursor pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            sx        <= '0;
            sy        <= '0;
            cur_x     <= HINIT10;
            cur_y     <= VINIT10;
            btn_level <= '0;
            pkt_cnt   <= '0;
        end else begin
            v1 <= m_done_tick;
            if (m_done_tick) begin
                sx        <= $signed({2'b00, base_x}) + dx;
                sy        <= $signed({2'b00, base_y}) - dy;
                btn_level <= btn;
                pkt_cnt   <= pkt_cnt + 16'd1;
            end
            if (home) begin
                cur_x <= HINIT10;
                cur_y <= VINIT10;
            end else if (commit) begin
                cur_x <= clx;
                cur_y <= cly;
            end
        end
    end

    // Sticky flags: a set in the same cycle as a read-clear survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            moved <= 1'b0;
            press <= '0;
            irq   <= 1'b0;
        end else begin
            moved <= (moved & ~clr) | set_moved;
            press <= (press & ~{3{clr}}) | set_press;
            irq   <= moved | (|press);
        end
    end

    // Registered read port, holds until the next read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            unique case (addr)
                2'd0: rd_data <= {6'b0, cur_x};
                2'd1: rd_data <= {6'b0, cur_y};
                2'd2: rd_data <= {8'b0, moved, press, 1'b0, btn_level};
                2'd3: rd_data <= pkt_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_cursor.sv
// Directed bench for mouse_cursor: expected values queued as stimulus is
// driven, popped and compared when the DUT output is sampled.
module tb_mouse_cursor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_done_tick;
    logic [8:0]  x, y;
    logic [2:0]  btn;
    logic        home;
    logic        rd_en;
    logic [1:0]  addr;
    logic [15:0] rd_data, rd_data2;
    logic [9:0]  cur_x, cur_y, cur_x2, cur_y2;
    logic [2:0]  btn_level, btn_level2;
    logic        irq, irq2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    mouse_cursor dut (
        .clk(clk), .rst_n(rst_n), .m_done_tick(m_done_tick), .x(x), .y(y),
        .btn(btn), .home(home), .rd_en(rd_en), .addr(addr), .rd_data(rd_data),
        .cur_x(cur_x), .cur_y(cur_y), .btn_level(btn_level), .irq(irq)
    );

    mouse_cursor #(.SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .m_done_tick(m_done_tick), .x(x), .y(y),
        .btn(btn), .home(home), .rd_en(rd_en), .addr(addr), .rd_data(rd_data2),
        .cur_x(cur_x2), .cur_y(cur_y2), .btn_level(btn_level2), .irq(irq2)
    );

    task automatic push(input string t, input logic [15:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [15:0] obs);
        logic [15:0] e;
        string t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_bad++;
                $error("FAIL %s: observed %0h (%0d) expected %0h (%0d)", t, obs, obs, e, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [8:0] tx, input logic [8:0] ty, input logic [2:0] tb);
        m_done_tick = 1'b1;
        x = tx;
        y = ty;
        btn = tb;
        step();
        m_done_tick = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        rd_en = 1'b1;
        addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_home();
        home = 1'b1;
        step();
        home = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; m_done_tick = 1'b0; x = '0; y = '0; btn = '0;
        home = 1'b0; rd_en = 1'b0; addr = '0;
        step(); step();

        // reset state
        push("rst_cur_x", 16'd320);   check({6'b0, cur_x});
        push("rst_cur_y", 16'd240);   check({6'b0, cur_y});
        push("rst_irq", 16'd0);       check({15'b0, irq});
        push("rst_rd_data", 16'd0);   check(rd_data);
        push("rst_btn_level", 16'd0); check({13'b0, btn_level});
        rst_n = 1'b1;
        step();
        rd(2'd0); push("rd_x_reset", 16'd320); check(rd_data);
        rd(2'd1); push("rd_y_reset", 16'd240); check(rd_data);
        rd(2'd3); push("rd_cnt_reset", 16'd0); check(rd_data);

        // back-to-back ticks, second forwards the first's clamped result
        tick(9'h001, 9'h000, 3'b000);
        tick(9'h001, 9'h000, 3'b000);
        step();
        push("b2b_cur_x", 16'd322); check({6'b0, cur_x});
        rd(2'd3); push("b2b_pkt_cnt", 16'd2); check(rd_data);
        rd(2'd2); push("b2b_moved", 16'h0080); check(rd_data);

        // home returns to init and does not set moved
        do_home();
        push("home_x", 16'd320); check({6'b0, cur_x});
        push("home_y", 16'd240); check({6'b0, cur_y});
        rd(2'd2); push("home_no_moved", 16'h0000); check(rd_data);

        // basic move, 2-cycle latency, moved flag and read-clear
        tick(9'h00A, 9'h005, 3'b000);
        push("lat1_cur_x", 16'd320); check({6'b0, cur_x});
        step();
        push("move_x", 16'd330); check({6'b0, cur_x});
        push("move_y", 16'd235); check({6'b0, cur_y});
        step();
        push("move_irq", 16'd1); check({15'b0, irq});
        rd(2'd2); push("moved_set", 16'h0080); check(rd_data);
        rd(2'd2); push("moved_cleared", 16'h0000); check(rd_data);

        // home kills an in-flight commit
        do_home();
        tick(9'h00A, 9'h000, 3'b000);
        do_home();
        step();
        push("home_kill_x", 16'd320); check({6'b0, cur_x});
        rd(2'd2); push("home_kill_flags", 16'h0000); check(rd_data);

        // tick coincident with home is applied on top of home position
        tick(9'h00A, 9'h000, 3'b000);
        step();
        home = 1'b1;
        tick(9'h005, 9'h000, 3'b000);
        home = 1'b0;
        step();
        push("home_tick_x", 16'd325); check({6'b0, cur_x});
        push("home_tick_y", 16'd240); check({6'b0, cur_y});

        // reset mid-pipeline discards the pending commit
        tick(9'h00A, 9'h000, 3'b000);
        rst_n = 1'b0;
        #2;
        push("mid_rst_x", 16'd320); check({6'b0, cur_x});
        rst_n = 1'b1;
        step(); step();
        push("post_rst_x", 16'd320); check({6'b0, cur_x});
        rd(2'd3); push("post_rst_cnt", 16'd0); check(rd_data);

        // walk to (5,470), then clamp at low X / high Y
        tick(9'h100, 9'h11A, 3'b000);
        tick(9'h1C5, 9'h000, 3'b000);
        step();
        push("walk_x", 16'd5);   check({6'b0, cur_x});
        push("walk_y", 16'd470); check({6'b0, cur_y});
        rd(2'd2);
        tick(9'h1F0, 9'h1F0, 3'b000);
        step();
        push("clamp_x0", 16'd0);   check({6'b0, cur_x});
        push("clamp_y479", 16'd479); check({6'b0, cur_y});
        rd(2'd2); push("clamp_moved", 16'h0080); check(rd_data);
        tick(9'h1F0, 9'h1F0, 3'b000);
        step();
        push("pin_x", 16'd0);   check({6'b0, cur_x});
        push("pin_y", 16'd479); check({6'b0, cur_y});
        rd(2'd2); push("pin_no_moved", 16'h0000); check(rd_data);

        // SHIFT=2 instance clamps on scaled deltas
        do_home();
        push("s2_home_x", 16'd320); check({6'b0, cur_x2});
        tick(9'h100, 9'h000, 3'b000);
        step();
        push("s2_clamp_lo", 16'd0); check({6'b0, cur_x2});
        push("s0_minus256", 16'd64); check({6'b0, cur_x});
        tick(9'h0FF, 9'h000, 3'b000);
        step();
        push("s2_clamp_hi", 16'd639); check({6'b0, cur_x2});
        push("s2_y_same", 16'd240);   check({6'b0, cur_y2});
        push("s0_plus255", 16'd319);  check({6'b0, cur_x});
        rd(2'd0); push("s2_rd_x", 16'd639); check(rd_data2);

        // button press edges, read-clear racing a new press
        do_home();
        rd(2'd2);
        tick(9'h000, 9'h000, 3'b001);
        tick(9'h000, 9'h000, 3'b011);
        tick(9'h000, 9'h000, 3'b001);
        push("btn_irq", 16'd1); check({15'b0, irq});
        rd_en = 1'b1; addr = 2'd2;
        tick(9'h000, 9'h000, 3'b011);
        rd_en = 1'b0;
        push("btn_read_race", 16'h0031); check(rd_data);
        push("btn_level", 16'd3); check({13'b0, btn_level});
        rd(2'd2); push("btn_press1_kept", 16'h0023); check(rd_data);
        rd(2'd2); push("btn_cleared", 16'h0003); check(rd_data);
        step();
        push("irq_low", 16'd0); check({15'b0, irq});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mouse_cursor.md
# mouse_cursor

Downstream consumer of the PS/2 mouse packet decoder. It integrates the signed per-packet X/Y deltas into an absolute, screen-clamped cursor position. It detects button press edges into sticky flags and exposes everything through a small registered read port for the CPU and the VGA cursor overlay. Each accepted packet moves through a two-stage pipeline: sign-extend/scale/add, then clamp/commit.

## Interface
Parameters:
- H_MAX, 639: largest legal cursor X (inclusive).
- V_MAX, 479: largest legal cursor Y (inclusive).
- H_INIT, 320: cursor X after reset or home.
- V_INIT, 240: cursor Y after reset or home.
- SHIFT, 0: left-shift applied to each delta, legal values 0..2 (sensitivity).

Ports:
- clk  in  1  system clock; the block's one clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m_done_tick  in  1  one-cycle strobe, packet fields valid.
- x  in  9  X delta, two's complement, bit 8 = sign.
- y  in  9  Y delta, two's complement, bit 8 = sign, positive = mouse moved up.
- btn  in  3  button levels {middle, right, left}, 1 = pressed.
- home  in  1  one-cycle strobe, cursor returns to (H_INIT, V_INIT).
- rd_en  in  1  CPU read strobe.
- addr  in  2  register select.
- rd_data  out  16  registered read data.
- cur_x  out  10  committed cursor X.
- cur_y  out  10  committed cursor Y.
- btn_level  out  3  registered copy of btn, captured on m_done_tick.
- irq  out  1  OR of all sticky flags.

## Operation
- Stage 1 on m_done_tick:
  - sign-extend x and y to 12 bits and shift left by SHIFT;
  - sx = {2'b0,cur_x} + dx;
  - sy = {2'b0,cur_y} − dy (screen Y grows downward);
  - latch btn into btn_level;
  - set v1.
- Stage 2 when v1:
  - if sx < 0, cur_x = 0; else if sx > H_MAX, cur_x = H_MAX; else cur_x = sx[9:0]. Y is handled the same way with V_MAX.
  - moved flag is set if the committed value differs from the old value on either axis.
- Press detection at stage 1: press[i] is set when btn[i]=1 and btn_level[i]=0 (prior value).
- Sticky flags are {moved, press[2:0]}. Read of addr 2 clears them. If a set and a clear occur in the same cycle, the set wins.
- Register map (read only):
  - 0: {6'b0, cur_x}.
  - 1: {6'b0, cur_y}.
  - 2: {8'b0, moved, press[2:0], 1'b0, btn_level}.
  - 3: pkt_cnt, 16-bit count of m_done_tick, wraps 0xFFFF→0.
- home:
  - loads cur_x/cur_y with H_INIT/V_INIT and kills an in-flight stage-2 commit;
  - a stage-1 capture in the same cycle is applied on top of the home position;
  - does not set moved.
- Reset values: cur_x=H_INIT, cur_y=V_INIT, btn_level=0, sticky flags=0, pkt_cnt=0, rd_data=0, irq=0, v1=0.

## Timing
- cur_x/cur_y update on the 2nd rising edge after m_done_tick is sampled high; latency is 2 cycles.
- Back-to-back m_done_tick on consecutive cycles must both be applied. Stage 1 uses the stage-2 result when v1 is set (forward the clamped value); no delta is lost.
- rd_data is valid in the cycle after rd_en and holds until the next rd_en.
- A read of addr 2 returns the flags before the clear. A press arriving in the clear cycle remains set.
- irq is registered and follows the sticky flags with 1 cycle of delay.
- Reset asserted mid-pipeline discards v1 and the stage-1 sums immediately.

## Test plan
- Reset, then read addr 0/1 → 320 / 240; irq=0.
- Tick with x=9'h00A, y=9'h005 → 2 cycles later cur_x=330, cur_y=235; addr 2 bit 7 (moved)=1; second read of addr 2 → bit 7=0.
- From (5,470), tick with x=9'h1F0 (−16), y=9'h1F0 (−16) → cur_x=0, cur_y=479. A further identical tick leaves the position unchanged and moved stays 0.
- SHIFT=2 instance, from (320,240), tick with x=9'h100 (−256) → raw sum is −704, so cur_x clamps to 0. Then tick with x=9'h0FF → cur_x=639.
- Ticks on two consecutive cycles, each x=+1 → cur_x=322; pkt_cnt=2.
- btn=3'b001 tick, then btn=3'b011 tick → press=3'b011, irq=1. Read addr 2 with a new right-button rising edge in the same cycle → read shows 3'b011 and press[1] stays set afterward.
